iter_alu: RTL and testbench

//   Parametrised multi-cycle ALU for the next CPU generation. Keeps the legacy 4-bit aluc

---
 rtl/iter_alu.sv | 183 ++++++++++++++++++
 tb/tb_iter_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// ============================================================================
// Module   : iter_alu
// Purpose  : Multi-cycle ALU: registered legacy aluc ops plus iterative mul/div.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] hi,
   output logic             z
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] c_steps = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] c_last  = (SHW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [SHW:0]     r_count;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] r_hi;
   logic             r_z;
   logic             r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz;

   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_legacy;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_sh;
   logic [WIDTH:0]   w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_nxt_acc;
   logic [WIDTH-1:0] w_nxt_q;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_fin_lo;
   logic [WIDTH-1:0] w_fin_hi;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign s         = r_s;
   assign hi        = r_hi;
   assign z         = r_z;

   assign w_shamt = a[SHW-1:0];

   always_comb begin
      w_legacy = '0;
      case (op[3:0])
         4'b0000, 4'b1000: w_legacy = a + b;
         4'b0100, 4'b1100: w_legacy = a - b;
         4'b0001, 4'b1001: w_legacy = a & b;
         4'b0101, 4'b1101: w_legacy = a | b;
         4'b0010, 4'b1010: w_legacy = a ^ b;
         4'b0110, 4'b1110: w_legacy = a << (WIDTH/2);
         4'b0011:          w_legacy = b << w_shamt;
         4'b0111:          w_legacy = b >> w_shamt;
         4'b1111:          w_legacy = $signed(b) >>> w_shamt;
         default:          w_legacy = '0;
      endcase
   end

   // Iterate on magnitudes; signs are re-applied on the final step
   assign w_a_neg = op[0] & a[WIDTH-1];
   assign w_b_neg = op[0] & b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;

   // Shift-add multiply: {acc,q} shifts right, multiplier bits consumed from q[0]
   assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

   // Restoring divide: remainder in acc, dividend bits shift out of q as quotient bits shift in
   assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
   assign w_div_diff = w_div_sh - {1'b0, r_m};
   assign w_div_ge   = (w_div_sh >= {1'b0, r_m});

   always_comb begin
      w_nxt_acc = w_mul_sum[WIDTH:1];
      w_nxt_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
      if (r_div) begin
         w_nxt_acc = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
         w_nxt_q   = {r_q[WIDTH-2:0], w_div_ge};
      end
   end

   assign w_prod = r_neg_q ? -{w_nxt_acc, w_nxt_q} : {w_nxt_acc, w_nxt_q};

   // With a zero divisor every step subtracts nothing, so acc ends holding |a|
   always_comb begin
      w_fin_lo = w_prod[WIDTH-1:0];
      w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
      if (r_div) begin
         w_fin_lo = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_nxt_q : w_nxt_q);
         w_fin_hi = r_neg_r ? -w_nxt_acc : w_nxt_acc;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_count <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_s     <= '0;
         r_hi    <= '0;
         r_z     <= 1'b1;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else if (abort) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (!op[4]) begin
                     r_s     <= w_legacy;
                     r_hi    <= '0;
                     r_z     <= (w_legacy == '0);
                     r_state <= DONE;
                  end else begin
                     r_acc   <= '0;
                     r_q     <= w_a_mag;
                     r_m     <= w_b_mag;
                     r_div   <= op[1];
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                     r_dz    <= op[1] & (b == '0);
                     r_count <= c_steps;
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_acc   <= w_nxt_acc;
               r_q     <= w_nxt_q;
               r_count <= r_count - c_last;
               if (r_count == c_last) begin
                  r_s     <= w_fin_lo;
                  r_hi    <= w_fin_hi;
                  r_z     <= (w_fin_lo == '0);
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iter_alu.sv
// ============================================================================
// Module   : tb_iter_alu
// Purpose  : Directed-vector self-checking bench for iter_alu (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_alu;

   logic        clock;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        abort;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] s;
   logic [31:0] hi;
   logic        z;

   int n_vec;
   int n_err;

   iter_alu #(.WIDTH(32)) dut (
      .clock    (clock),
      .resetn   (resetn),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .abort    (abort),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s        (s),
      .hi       (hi),
      .z        (z)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Latency is counted in rising edges after the accept edge until out_valid is seen
   task automatic run(input string tag, input logic [4:0] o, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] es, input logic [31:0] ehi,
                      input logic ez, input int elat, input int hold);
      int t;
      out_ready = (hold == 0);
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      op = o;
      a  = av;
      b  = bv;
      @(negedge clock);
      in_valid = 1'b0;
      a  = 32'hDEAD_BEEF;
      b  = 32'h1234_5678;
      op = ~o;
      t = 0;
      while (!out_valid && t < 200) begin
         @(negedge clock);
         t++;
      end
      chk({tag, ".lat"}, 64'(t), 64'(elat));
      chk({tag, ".s"},   64'(s),  64'(es));
      chk({tag, ".hi"},  64'(hi), 64'(ehi));
      chk({tag, ".z"},   64'(z),  64'(ez));
      if (hold > 0) begin
         repeat (hold) @(negedge clock);
         chk({tag, ".hold_v"}, 64'(out_valid), 64'(1));
         chk({tag, ".hold"}, {s, hi}, {es, ehi});
         out_ready = 1'b1;
      end
      @(negedge clock);
      chk({tag, ".ack"}, 64'(out_valid), 64'(0));
      chk({tag, ".keep"}, {s, hi}, {es, ehi});
   endtask

   initial begin
      int  t;
      logic seen;
      n_vec     = 0;
      n_err     = 0;
      resetn    = 1'b0;
      in_valid  = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      abort     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst.valid", 64'(out_valid), 64'(0));
      chk("rst.ready", 64'(in_ready),  64'(1));
      chk("rst.s",     64'(s),  64'(0));
      chk("rst.hi",    64'(hi), 64'(0));
      chk("rst.z",     64'(z),  64'(1));
      resetn = 1'b1;
      @(negedge clock);

      run("add",   5'b0_0000, 32'd7,        32'd5,          32'd12,          32'd0, 1'b0, 0, 0);
      run("sra",   5'b0_1111, 32'd4,        32'h8000_0000,  32'hF800_0000,   32'd0, 1'b0, 0, 0);
      run("sub0",  5'b0_0100, 32'd9,        32'd9,          32'd0,           32'd0, 1'b1, 0, 0);
      run("and",   5'b0_0001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,   32'd0, 1'b0, 0, 0);
      run("or",    5'b0_1101, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0,   32'd0, 1'b0, 0, 0);
      run("xor",   5'b0_0010, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0,   32'd0, 1'b0, 0, 0);
      run("lui",   5'b0_0110, 32'h0000_1234, 32'd0,         32'h1234_0000,   32'd0, 1'b0, 0, 0);
      run("sll",   5'b0_0011, 32'd36,       32'd1,          32'd16,          32'd0, 1'b0, 0, 0);
      run("srl",   5'b0_0111, 32'd4,        32'h8000_0000,  32'h0800_0000,   32'd0, 1'b0, 0, 0);
      run("subw",  5'b0_1100, 32'd0,        32'd1,          32'hFFFF_FFFF,   32'd0, 1'b0, 0, 0);
      run("inval", 5'b0_1011, 32'd1,        32'd1,          32'd0,           32'd0, 1'b1, 0, 0);
      run("mul",   5'b1_0001, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0003, 32'hFFFF_FFFE, 1'b0, 32, 0);
      run("mulu",  5'b1_1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32, 0);
      run("mul0",  5'b1_0001, 32'hFFFF_FFFB, 32'd0,         32'd0,         32'd0,         1'b1, 32, 0);
      run("div",   5'b1_0011, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32, 0);
      run("divovf",5'b1_0011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 32, 0);
      run("div_nd",5'b1_0011, 32'd7,        32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0, 32, 0);
      run("divu",  5'b1_0010, 32'd100,      32'd7,          32'd14,        32'd2,         1'b0, 32, 0);
      run("divu0", 5'b1_0010, 32'd100,      32'd0,          32'hFFFF_FFFF, 32'd100,       1'b0, 32, 5);
      run("divs0", 5'b1_0011, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 32, 0);

      // Abort mid-multiply: last delivered result (divs0) must survive
      out_ready = 1'b1;
      in_valid = 1'b1;
      op = 5'b1_0000;
      a  = 32'd3;
      b  = 32'd5;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (9) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk("abort.ready", 64'(in_ready),  64'(1));
      chk("abort.valid", 64'(out_valid), 64'(0));
      chk("abort.keep",  {s, hi}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (out_valid) seen = 1'b1;
      end
      chk("abort.noout", 64'(seen), 64'(0));

      // Abort beats a simultaneous accept
      in_valid = 1'b1;
      abort = 1'b1;
      op = 5'b0_0000;
      a  = 32'd1;
      b  = 32'd1;
      @(negedge clock);
      in_valid = 1'b0;
      abort = 1'b0;
      chk("abort.acc", 64'(out_valid), 64'(0));

      // Reset mid-divide
      in_valid = 1'b1;
      op = 5'b1_0011;
      a  = 32'd100;
      b  = 32'd7;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (5) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      chk("rstmid.valid", 64'(out_valid), 64'(0));
      chk("rstmid.ready", 64'(in_ready),  64'(1));
      chk("rstmid.s",     64'(s),  64'(0));
      chk("rstmid.z",     64'(z),  64'(1));
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      run("post", 5'b0_1000, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 0, 0);

      t = n_err;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, t);
      $finish;
   end

endmodule

`default_nettype wire
